// File: rtl/shader_pipeline.sv
// Single-cycle SIMD shader core: fixed 16-instruction ROM, 4-lane x 8-bit
// register file, per-lane ADD/SUB/MUL, bitwise AND/OR/XOR, broadcast LDI, HALT.

// Register file: two combinational read ports, one synchronous write port.
module shader_regfile #(
  parameter int unsigned W     = 32,
  parameter int unsigned NREGS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr1,
  input  logic [3:0]   raddr2,
  output logic [W-1:0] rdata1,
  output logic [W-1:0] rdata2
);
  logic [W-1:0] reg_file [NREGS];

  // Reads see the pre-edge contents, so rd == rs1/rs2 returns the old value.
  assign rdata1 = reg_file[raddr1];
  assign rdata2 = reg_file[raddr2];

  // Write port; reset clears every register asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) reg_file[i] <= '0;
    end else if (we) begin
      reg_file[waddr] <= wdata;
    end
  end
endmodule

module shader_pipeline #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned NREGS  = 16
) (
  input  logic clk,
  input  logic rst
);
  localparam int unsigned W = LANES * LANE_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_MUL  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_LDI  = 4'h7,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t       state, state_d;
  logic [3:0]   pc, pc_d;
  logic         halted;
  logic [15:0]  instr;
  opcode_t      op;
  logic [3:0]   rd, rs1, rs2;
  logic [7:0]   imm8;
  logic [W-1:0] rs1v, rs2v, alu;
  logic         we;

  assign halted = (state == S_HALT);

  // Program ROM; unlisted addresses are NOP.
  always_comb begin
    instr = '0;
    case (pc)
      4'd0:    instr = 16'h7001;
      4'd1:    instr = 16'h7102;
      4'd2:    instr = 16'h1201;
      4'd3:    instr = 16'h3321;
      4'd4:    instr = 16'h2001;
      4'd5:    instr = 16'hF000;
      default: instr = 16'h0000;
    endcase
  end

  assign op   = opcode_t'(instr[15:12]);
  assign rd   = instr[11:8];
  assign rs1  = instr[7:4];
  assign rs2  = instr[3:0];
  assign imm8 = instr[7:0];

  shader_regfile #(.W(W), .NREGS(NREGS)) regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (rd),
    .wdata  (alu),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1v),
    .rdata2 (rs2v)
  );

  // Lane-wise arithmetic keeps only the low LANE_W bits; no carry crosses lanes.
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD: for (int unsigned i = 0; i < LANES; i++)
                alu[i*LANE_W +: LANE_W] = rs1v[i*LANE_W +: LANE_W] + rs2v[i*LANE_W +: LANE_W];
      OP_SUB: for (int unsigned i = 0; i < LANES; i++)
                alu[i*LANE_W +: LANE_W] = rs1v[i*LANE_W +: LANE_W] - rs2v[i*LANE_W +: LANE_W];
      OP_MUL: for (int unsigned i = 0; i < LANES; i++)
                alu[i*LANE_W +: LANE_W] = rs1v[i*LANE_W +: LANE_W] * rs2v[i*LANE_W +: LANE_W];
      OP_AND: alu = rs1v & rs2v;
      OP_OR:  alu = rs1v | rs2v;
      OP_XOR: alu = rs1v ^ rs2v;
      OP_LDI: for (int unsigned i = 0; i < LANES; i++)
                alu[i*LANE_W +: LANE_W] = LANE_W'(imm8);
      default: alu = '0;
    endcase
  end

  // Next-state: HALT freezes pc at its own address and blocks all writes.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    we      = 1'b0;
    if (!halted) begin
      if (op == OP_HALT) begin
        state_d = S_HALT;
      end else begin
        pc_d = pc + 4'd1;
        we   = op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LDI};
      end
    end
  end

  // State and program-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      pc    <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
    end
  end
endmodule

// File: tb/tb_shader_pipeline.sv
// Self-checking bench for shader_pipeline: an ISA-level reference model pushes
// the expected architectural state for every clock edge; a monitor pops and
// compares it shortly after the edge.
module tb_shader_pipeline;
  logic clk = 1'b0;
  logic rst = 1'b1;

  shader_pipeline #(.LANES(4), .LANE_W(8), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        pc;
    logic [15:0][31:0] r;
  } snap_t;

  snap_t      sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model state.
  logic [15:0] prog [16];
  logic [3:0]  m_pc;
  logic        m_halted;
  logic [31:0] m_r [16];

  function automatic void model_reset();
    m_pc = '0;
    m_halted = 1'b0;
    for (int k = 0; k < 16; k++) m_r[k] = '0;
  endfunction

  function automatic void model_exec();
    logic [15:0] ins;
    logic [31:0] a, b, res;
    logic [7:0]  x, y;
    bit          wr;
    if (m_halted) return;
    ins = prog[m_pc];
    a = m_r[ins[7:4]];
    b = m_r[ins[3:0]];
    res = '0;
    wr = 1'b1;
    for (int ln = 0; ln < 4; ln++) begin
      x = a[8*ln +: 8];
      y = b[8*ln +: 8];
      case (ins[15:12])
        4'h1: res[8*ln +: 8] = 8'((16'(x) + 16'(y)) % 256);
        4'h2: res[8*ln +: 8] = 8'((16'(x) + 16'd256 - 16'(y)) % 256);
        4'h3: res[8*ln +: 8] = 8'((16'(x) * 16'(y)) % 256);
        4'h7: res[8*ln +: 8] = ins[7:0];
        default: ;
      endcase
    end
    case (ins[15:12])
      4'h4: res = a & b;
      4'h5: res = a | b;
      4'h6: res = a ^ b;
      default: ;
    endcase
    if (ins[15:12] == 4'hF) begin
      m_halted = 1'b1;
      wr = 1'b0;
    end else if (ins[15:12] == 4'h0 || ins[15:12] > 4'h7) begin
      wr = 1'b0;
    end
    if (wr) m_r[ins[11:8]] = res;
    if (!m_halted) m_pc = m_pc + 4'd1;
  endfunction

  // One clock of stimulus: drive rst at the negedge, advance model, push expectation.
  task automatic drive_cycle(input logic rst_val);
    snap_t s;
    @(negedge clk);
    rst = rst_val;
    if (rst_val) model_reset();
    else model_exec();
    s.pc = m_pc;
    for (int k = 0; k < 16; k++) s.r[k] = m_r[k];
    sb_q.push_back(s);
  endtask

  task automatic drain();
    @(posedge clk);
    #3;
  endtask

  // Scoreboard monitor: compare DUT state 2 time units after each rising edge.
  always @(posedge clk) begin
    snap_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (dut.pc !== e.pc) begin
        n_fail++;
        $display("FAIL sb_pc t=%0t got=%0d exp=%0d", $time, dut.pc, e.pc);
      end
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (dut.regfile.reg_file[k] !== e.r[k]) begin
          n_fail++;
          $display("FAIL sb_r%0d t=%0t got=%h exp=%h", k, $time, dut.regfile.reg_file[k], e.r[k]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    n_checks++;
    #1;
    if (dut.pc !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_pc_initial got=%0d exp=0", dut.pc);
    end
    for (int c = 0; c < 4; c++) drive_cycle(1'b1);
    drain();
  endtask

  task automatic test_program();
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b0);
      if (i == 4) begin
        n_checks += 5;
        if (dut.pc !== 4'd3) begin n_fail++; $display("FAIL e3_pc got=%0d exp=3", dut.pc); end
        if (dut.regfile.reg_file[0] !== 32'h01010101) begin n_fail++; $display("FAIL e3_r0 got=%h exp=01010101", dut.regfile.reg_file[0]); end
        if (dut.regfile.reg_file[1] !== 32'h02020202) begin n_fail++; $display("FAIL e3_r1 got=%h exp=02020202", dut.regfile.reg_file[1]); end
        if (dut.regfile.reg_file[2] !== 32'h03030303) begin n_fail++; $display("FAIL e3_r2 got=%h exp=03030303", dut.regfile.reg_file[2]); end
        if (dut.regfile.reg_file[3] !== 32'h00000000) begin n_fail++; $display("FAIL e3_r3 got=%h exp=00000000", dut.regfile.reg_file[3]); end
      end
      if (i == 6) begin
        n_checks += 3;
        if (dut.pc !== 4'd5) begin n_fail++; $display("FAIL e5_pc got=%0d exp=5", dut.pc); end
        if (dut.regfile.reg_file[3] !== 32'h06060606) begin n_fail++; $display("FAIL e5_r3 got=%h exp=06060606", dut.regfile.reg_file[3]); end
        if (dut.regfile.reg_file[0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL e5_r0 got=%h exp=FFFFFFFF", dut.regfile.reg_file[0]); end
      end
    end
    drain();
  endtask

  task automatic test_halt_hold();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0);
    drain();
    n_checks += 5;
    if (dut.pc !== 4'd5) begin n_fail++; $display("FAIL halt_pc got=%0d exp=5", dut.pc); end
    if (dut.regfile.reg_file[0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL halt_r0 got=%h exp=FFFFFFFF", dut.regfile.reg_file[0]); end
    if (dut.regfile.reg_file[1] !== 32'h02020202) begin n_fail++; $display("FAIL halt_r1 got=%h exp=02020202", dut.regfile.reg_file[1]); end
    if (dut.regfile.reg_file[2] !== 32'h03030303) begin n_fail++; $display("FAIL halt_r2 got=%h exp=03030303", dut.regfile.reg_file[2]); end
    if (dut.regfile.reg_file[3] !== 32'h06060606) begin n_fail++; $display("FAIL halt_r3 got=%h exp=06060606", dut.regfile.reg_file[3]); end
  endtask

  task automatic test_midrun_reset();
    drive_cycle(1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0);
    drain();
    n_checks++;
    if (dut.pc !== 4'd4) begin n_fail++; $display("FAIL mid_pre_pc got=%0d exp=4", dut.pc); end
    // Assert reset between edges; state must clear without a clock edge.
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut.pc !== 4'd0) begin n_fail++; $display("FAIL mid_async_pc got=%0d exp=0", dut.pc); end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (dut.regfile.reg_file[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_async_r%0d got=%h exp=00000000", k, dut.regfile.reg_file[k]);
      end
    end
    drive_cycle(1'b1);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    prog[0] = 16'h7001; prog[1] = 16'h7102; prog[2] = 16'h1201;
    prog[3] = 16'h3321; prog[4] = 16'h2001; prog[5] = 16'hF000;
    for (int k = 6; k < 16; k++) prog[k] = 16'h0000;
    model_reset();
    test_reset();
    test_program();
    test_halt_hold();
    test_midrun_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shader_pipeline.md
SHADER_PIPELINE -- requirements
Module: shader_pipeline

Interface
REQ-001 SHALL have parameter LANES, default 4, number of SIMD lanes per register.
REQ-002 SHALL have parameter LANE_W, default 8, bits per lane; register width = LANES*LANE_W = 32.
REQ-003 SHALL have parameter NREGS, default 16, register count (4-bit register fields).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have no other ports; state is observed hierarchically via dut.pc (4-bit reg) and dut.regfile.reg_file[0..15] (32-bit array inside a register-file submodule instance named regfile).

Function
REQ-007 SHALL execute one instruction per clock from an internal 16-entry x 16-bit instruction ROM indexed by pc; single-cycle fetch/decode/execute/writeback.
REQ-008 SHALL decode the instruction as [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; LDI uses [7:0] as imm8.
REQ-009 SHALL implement opcodes: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 LDI, F HALT; 8-E behave as NOP.
REQ-010 SHALL compute ADD/SUB/MUL per lane independently, keeping the low LANE_W bits (modulo 256 wrap, no inter-lane carry, no saturation).
REQ-011 SHALL compute AND/OR/XOR bitwise over all 32 bits.
REQ-012 SHALL write LDI as rd <= {LANES{imm8}} (imm8 broadcast to every lane).
REQ-013 SHALL provide regfile with two combinational read ports (rs1, rs2) and one synchronous write port (rd, data, write-enable); write enable asserted only for opcodes 1-7.
REQ-014 SHALL read the old value when rd equals rs1/rs2 in the same instruction (write takes effect at the clock edge).
REQ-015 SHALL advance pc by 1 per clock, wrapping 15 -> 0, except as in REQ-016.
REQ-016 SHALL, on HALT, hold pc at the HALT address and perform no writes until reset; a halted flag latches this state.
REQ-017 SHALL hold this fixed ROM program: 0: LDI r0,0x01; 1: LDI r1,0x02; 2: ADD r2,r0,r1; 3: MUL r3,r2,r1; 4: SUB r0,r0,r1; 5: HALT; 6-15: NOP (0x0000).
REQ-018 SHALL encode the program as 0x7001, 0x7102, 0x1201, 0x3321, 0x2001, 0xF000.

Reset
REQ-019 SHALL, while rst=1, immediately force pc=0, halted=0 and all 16 registers to 0x00000000, regardless of clk.
REQ-020 SHALL execute ROM[0] at the first rising clk edge after rst falls.
REQ-021 SHALL abort any in-progress program on mid-run reset and restart from pc=0 with cleared registers.

Verification
REQ-022 Reset held, clk toggling -> pc=0, r0..r3=00000000 throughout.
REQ-023 Release reset, 3 edges -> pc=3, r0=01010101, r1=02020202, r2=03030303, r3=00000000.
REQ-024 Release reset, 5 edges -> r3=06060606, r0=FFFFFFFF (per-lane borrow wrap, no cross-lane effect), pc=5.
REQ-025 Release reset, 10 edges -> pc stays 5 (halted); r0=FFFFFFFF, r1=02020202, r2=03030303, r3=06060606 unchanged.
REQ-026 Assert rst asynchronously mid-clock after 4 edges -> pc and all registers zero before next edge; after release program re-runs identically.
REQ-027 Registers r4..r15 remain 00000000 for the whole run (NOP/HALT never write).
